// File: rtl/horizontal_tf_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : horizontal_tf_sched_if
// Brief    : Control/status bundle between a pass requester and the
//            horizontal twiddle-factor sequencer.
// Revision : 1.0
// ============================================================================
interface horizontal_tf_sched_if #(
    parameter int DC_WIDTH = 13,
    parameter int DCNT_BP4 = 10
);
    logic                         start;
    logic [DC_WIDTH-DCNT_BP4-1:0] stage_counter;
    logic                         CEN;
    logic                         busy;
    logic                         done;
    logic [1:0]                   tf_mode;
    logic [3:0]                   group_idx;
    logic                         a_sel;
    logic                         const_load;
    logic                         issue;
    logic                         out_en;
    logic [5:0]                   out_addr;

    modport master (
        output start, stage_counter, CEN,
        input  busy, done, tf_mode, group_idx, a_sel, const_load, issue,
               out_en, out_addr
    );

    modport slave (
        input  start, stage_counter, CEN,
        output busy, done, tf_mode, group_idx, a_sel, const_load, issue,
               out_en, out_addr
    );
endinterface
`default_nettype wire

// File: rtl/horizontal_tf_sched.sv
`default_nettype none
// ============================================================================
// Module   : horizontal_tf_sched
// Brief    : Issues 64 twiddle multiply beats per stage-0 pass and times the
//            write-back enable behind the modular-multiplier pipeline.
// Revision : 1.0
// ============================================================================
module horizontal_tf_sched #(
    parameter int DC_WIDTH = 13,
    parameter int DCNT_BP4 = 10,
    parameter int MUL_LAT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    horizontal_tf_sched_if.slave bus
);

    localparam int c_STAGE_W = DC_WIDTH - DCNT_BP4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [5:0]           r_b;
    logic [5:0]           w_b_nxt;
    logic                 r_issue;
    logic                 w_issue_nxt;
    logic [1:0]           r_tf;
    logic [1:0]           w_tf_nxt;
    logic [3:0]           r_grp;
    logic [3:0]           w_grp_nxt;
    logic                 r_asel;
    logic                 w_asel_nxt;
    logic                 r_cload;
    logic                 w_cload_nxt;
    logic                 w_clear;
    logic [MUL_LAT-1:0]   r_dl;
    logic [MUL_LAT-1:0]   w_dl_shift;
    logic [5:0]           r_out_addr;
    logic                 w_stage_ok;

    assign w_stage_ok = (bus.stage_counter == {c_STAGE_W{1'b0}});

    // The delay line mirrors the free-running multiplier, so it shifts
    // regardless of CEN.
    generate
        if (MUL_LAT == 1) begin : g_dl_one
            assign w_dl_shift = r_issue;
        end else begin : g_dl_multi
            assign w_dl_shift = {r_dl[MUL_LAT-2:0], r_issue};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_issue_nxt = 1'b0;
        w_tf_nxt    = 2'd0;
        w_grp_nxt   = 4'd0;
        w_asel_nxt  = 1'b0;
        w_cload_nxt = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && w_stage_ok && !bus.CEN) begin
                    w_state_nxt = S_RUN;
                    w_b_nxt     = 6'd0;
                end
            end
            S_RUN: begin
                if (!w_stage_ok) begin
                    w_state_nxt = S_IDLE;
                    w_b_nxt     = 6'd0;
                    w_clear     = 1'b1;
                end else if (!bus.CEN) begin
                    w_issue_nxt = 1'b1;
                    w_tf_nxt    = r_b[5:4];
                    w_grp_nxt   = r_b[3:0];
                    w_asel_nxt  = (r_b[5:4] != 2'd0);
                    w_cload_nxt = (r_b[3:0] == 4'd0);
                    w_b_nxt     = r_b + 6'd1;
                    if (r_b == 6'd63) begin
                        w_state_nxt = S_DRAIN;
                    end
                end else begin
                    // Frozen: operand selects hold for the resumed beat.
                    w_tf_nxt   = r_tf;
                    w_grp_nxt  = r_grp;
                    w_asel_nxt = r_asel;
                end
            end
            S_DRAIN: begin
                if (!w_stage_ok) begin
                    w_state_nxt = S_IDLE;
                    w_b_nxt     = 6'd0;
                    w_clear     = 1'b1;
                end else if (w_dl_shift == {MUL_LAT{1'b0}}) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b        <= 6'd0;
            r_issue    <= 1'b0;
            r_tf       <= 2'd0;
            r_grp      <= 4'd0;
            r_asel     <= 1'b0;
            r_cload    <= 1'b0;
            r_dl       <= {MUL_LAT{1'b0}};
            r_out_addr <= 6'd0;
        end else begin
            r_b     <= w_b_nxt;
            r_issue <= w_issue_nxt;
            r_tf    <= w_tf_nxt;
            r_grp   <= w_grp_nxt;
            r_asel  <= w_asel_nxt;
            r_cload <= w_cload_nxt;
            if (w_clear) begin
                r_dl       <= {MUL_LAT{1'b0}};
                r_out_addr <= 6'd0;
            end else begin
                r_dl <= w_dl_shift;
                // 64 beats per pass, so the natural 6-bit wrap returns to 0.
                if (r_dl[MUL_LAT-1]) begin
                    r_out_addr <= r_out_addr + 6'd1;
                end
            end
        end
    end

    assign bus.busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done       = (r_state == S_DONE);
    assign bus.issue      = r_issue;
    assign bus.tf_mode    = r_tf;
    assign bus.group_idx  = r_grp;
    assign bus.a_sel      = r_asel;
    assign bus.const_load = r_cload;
    assign bus.out_en     = r_dl[MUL_LAT-1];
    assign bus.out_addr   = r_out_addr;

endmodule
`default_nettype wire

// File: tb/tb_horizontal_tf_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_horizontal_tf_sched
// Brief    : Scoreboard bench running MUL_LAT=4 and MUL_LAT=1 builds in
//            lockstep from one stimulus stream.
// Revision : 1.0
// ============================================================================
module tb_horizontal_tf_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    horizontal_tf_sched_if #(.DC_WIDTH(13), .DCNT_BP4(10)) bus4 ();
    horizontal_tf_sched_if #(.DC_WIDTH(13), .DCNT_BP4(10)) bus1 ();

    assign bus1.start         = bus4.start;
    assign bus1.stage_counter = bus4.stage_counter;
    assign bus1.CEN           = bus4.CEN;

    horizontal_tf_sched #(.DC_WIDTH(13), .DCNT_BP4(10), .MUL_LAT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    horizontal_tf_sched #(.DC_WIDTH(13), .DCNT_BP4(10), .MUL_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  tf;
        logic [3:0]  grp;
        logic        asel;
        logic        cload;
    } iss_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [5:0]  addr;
    } out_t;

    iss_t q_iss4[$];
    iss_t q_iss1[$];
    out_t q_out4[$];
    out_t q_out1[$];
    int   exp_done [2];
    int   busy_lo  [2];
    int   busy_hi  [2];
    bit   done_seen[2];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [17:0] outs4();
        return {bus4.busy, bus4.done, bus4.tf_mode, bus4.group_idx, bus4.a_sel,
                bus4.const_load, bus4.issue, bus4.out_en, bus4.out_addr};
    endfunction

    function automatic logic [17:0] outs1();
        return {bus1.busy, bus1.done, bus1.tf_mode, bus1.group_idx, bus1.a_sel,
                bus1.const_load, bus1.issue, bus1.out_en, bus1.out_addr};
    endfunction

    task automatic mon(input int d, input string p, input logic iss, input logic [1:0] tf,
                       input logic [3:0] grp, input logic asel, input logic cload,
                       input logic oen, input logic [5:0] oaddr, input logic bsy,
                       input logic dn);
        iss_t ei;
        out_t eo;
        int   n;
        chk({p, " busy"}, bsy, (cyc >= busy_lo[d] && cyc <= busy_hi[d]));
        if (iss) begin
            n = (d == 0) ? q_iss4.size() : q_iss1.size();
            if (n == 0) begin
                chk({p, " spurious_issue_cycle"}, cyc, 32'hFFFF_FFFF);
            end else begin
                if (d == 0) ei = q_iss4.pop_front();
                else        ei = q_iss1.pop_front();
                chk({p, " issue_cycle"}, cyc, ei.cyc);
                chk({p, " tf_mode"}, tf, ei.tf);
                chk({p, " group_idx"}, grp, ei.grp);
                chk({p, " a_sel"}, asel, ei.asel);
                chk({p, " const_load"}, cload, ei.cload);
            end
        end else begin
            chk({p, " const_load_no_issue"}, cload, 0);
        end
        if (!bsy) chk({p, " idle_selects"}, {tf, grp, asel}, 0);
        if (oen) begin
            n = (d == 0) ? q_out4.size() : q_out1.size();
            if (n == 0) begin
                chk({p, " spurious_out_en_cycle"}, cyc, 32'hFFFF_FFFF);
            end else begin
                if (d == 0) eo = q_out4.pop_front();
                else        eo = q_out1.pop_front();
                chk({p, " out_en_cycle"}, cyc, eo.cyc);
                chk({p, " out_addr"}, oaddr, eo.addr);
            end
        end
        if (dn) begin
            chk({p, " done_cycle"}, cyc, exp_done[d]);
            done_seen[d] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, "L4", bus4.issue, bus4.tf_mode, bus4.group_idx, bus4.a_sel,
                bus4.const_load, bus4.out_en, bus4.out_addr, bus4.busy, bus4.done);
            mon(1, "L1", bus1.issue, bus1.tf_mode, bus1.group_idx, bus1.a_sel,
                bus1.const_load, bus1.out_en, bus1.out_addr, bus1.busy, bus1.done);
        end
    end

    // One pass: expectations for both builds are queued before the start edge.
    // cut > 0 ends the pass (abort or reset) so only beats seen before cycle
    // s+cut are expected and no done pulse.
    task automatic run_pass(input int frz_b, input int frz_n, input int cut,
                            input bit do_abort, input bit do_rst, input int dup_b);
        int   s;
        int   c;
        int   last;
        int   lat;
        iss_t ei;
        out_t eo;
        @(negedge clk);
        #1;
        s = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            lat  = (d == 0) ? 4 : 1;
            c    = 1;
            last = 0;
            for (int b = 0; b < 64; b++) begin
                if (frz_n > 0 && b == frz_b + 1) c += frz_n;
                ei.cyc   = s + c;
                ei.tf    = b[5:4];
                ei.grp   = b[3:0];
                ei.asel  = (b >= 16);
                ei.cload = (b % 16 == 0);
                eo.cyc   = s + c + lat;
                eo.addr  = b[5:0];
                if (cut == 0 || c < cut) begin
                    if (d == 0) q_iss4.push_back(ei);
                    else        q_iss1.push_back(ei);
                end
                if (cut == 0 || c + lat < cut) begin
                    if (d == 0) q_out4.push_back(eo);
                    else        q_out1.push_back(eo);
                end
                last = c;
                c++;
            end
            exp_done[d]  = (cut == 0) ? s + last + lat + 1 : -1;
            busy_lo[d]   = s;
            busy_hi[d]   = (cut == 0) ? s + last + lat : s + cut - 1;
            done_seen[d] = 1'b0;
        end
        bus4.start = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            #1;
            bus4.start = (dup_b >= 0 && cyc + 1 == s + dup_b + 1);
            bus4.CEN   = (frz_n > 0 && cyc + 1 >= s + frz_b + 2 &&
                          cyc + 1 <= s + frz_b + 1 + frz_n);
            if (do_abort && cyc + 1 >= s + cut) bus4.stage_counter = 3'd2;
            if (do_rst && cyc == s + cut - 1) begin
                rst_n = 1'b0;
                #1;
                chk("L4 async_reset_outputs", outs4(), 0);
                chk("L1 async_reset_outputs", outs1(), 0);
            end else begin
                rst_n = 1'b1;
            end
        end
        bus4.start         = 1'b0;
        bus4.CEN           = 1'b0;
        bus4.stage_counter = 3'd0;
        rst_n              = 1'b1;
        chk("L4 issues_left", q_iss4.size(), 0);
        chk("L1 issues_left", q_iss1.size(), 0);
        chk("L4 outs_left", q_out4.size(), 0);
        chk("L1 outs_left", q_out1.size(), 0);
        if (cut == 0) begin
            chk("L4 done_seen", done_seen[0], 1);
            chk("L1 done_seen", done_seen[1], 1);
        end
        q_iss4.delete();
        q_iss1.delete();
        q_out4.delete();
        q_out1.delete();
    endtask

    initial begin
        bus4.start         = 1'b0;
        bus4.stage_counter = 3'd0;
        bus4.CEN           = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_done[d]  = -1;
            busy_lo[d]   = 1;
            busy_hi[d]   = 0;
            done_seen[d] = 1'b0;
        end

        repeat (2) @(negedge clk);
        chk("L4 reset_outputs", outs4(), 0);
        chk("L1 reset_outputs", outs1(), 0);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Nominal pass
        run_pass(-1, 0, 0, 1'b0, 1'b0, -1);

        // Freeze for 3 cycles after beat 20
        run_pass(20, 3, 0, 1'b0, 1'b0, -1);

        // Illegal starts: nonzero stage, then CEN high
        @(negedge clk);
        #1;
        bus4.stage_counter = 3'd1;
        bus4.start         = 1'b1;
        @(negedge clk);
        #1;
        bus4.stage_counter = 3'd0;
        bus4.CEN           = 1'b1;
        @(negedge clk);
        #1;
        bus4.start = 1'b0;
        bus4.CEN   = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("L4 illegal_start_busy", bus4.busy, 0);
        chk("L1 illegal_start_issue", bus1.issue, 0);

        // Abort: stage goes to 2 right after beat 30 issues
        run_pass(-1, 0, 32, 1'b1, 1'b0, -1);

        // Fresh pass after abort restarts from beat 0
        run_pass(-1, 0, 0, 1'b0, 1'b0, -1);

        // Second start at beat 10 is ignored
        run_pass(-1, 0, 0, 1'b0, 1'b0, 10);

        // Reset pulse during drain
        run_pass(-1, 0, 66, 1'b0, 1'b1, -1);

        // Post-reset pass: out_addr starts at 0 again
        run_pass(-1, 0, 0, 1'b0, 1'b0, -1);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
